boton_eventos: RTL and testbench
================================

Name: boton_eventos

Overview:
- Consumes the debounced button level from the debounce stage, one instance per button.
- Turns that level into single-cycle event pulses for the pet-logic FSM: press, short press, long press and release, plus a level that shows whether a long hold is active.
- Runs entirely in the system clock domain (50 MHz). The input is already debounced and is active-high (1 = pressed).

Parameters:
- LONG_CYCLES, 100_000_000, hold time in clk cycles that classifies a press as long (2 s at 50 MHz). Minimum legal value is 2.
- REPEAT_CYCLES, 25_000_000, auto-repeat period in clk cycles. Used only when REPEAT_EN is defined.
- CNT_W, 27, hold-counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- botondebounced  input  1  debounced button level, 1 = pressed, synchronous to clk
- pulse_press  output  1  one-cycle pulse on press
- pulse_short  output  1  one-cycle pulse on release of a short press
- pulse_long  output  1  one-cycle pulse when the hold reaches LONG_CYCLES
- pulse_release  output  1  one-cycle pulse on any release
- holding_long  output  1  level, 1 while in the long-held state
- pulse_repeat  output  1  one-cycle auto-repeat pulse (constant 0 without REPEAT_EN)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, btn_q=0, counter=0.
  - All outputs 0.
  - Deassertion is taken synchronously on the next clk edge.
- Input stage: btn_q registers botondebounced every edge.
  - rise = btn_q & ~btn_prev; fall = ~btn_q & btn_prev; btn_prev registers btn_q.
- All outputs are registered.
  - Latency: input rises before edge N → btn_q=1 after N → pulse_press=1 for exactly the cycle after edge N+1.
  - Release has the same 2-edge latency.
- States: IDLE, PRESSED, LONG_HELD.
- IDLE:
  - On rise: go to PRESSED, counter<=0, pulse_press<=1.
  - fall is impossible here and is ignored.
- PRESSED: counter increments every cycle.
  - Fall: pulse_short<=1, pulse_release<=1, go to IDLE, counter<=0.
  - counter==LONG_CYCLES-1 with no fall: pulse_long<=1, holding_long<=1, go to LONG_HELD, counter<=0.
  - Fall and threshold on the same cycle: fall wins. Result is a short press; pulse_long is not emitted.
- LONG_HELD:
  - On fall: pulse_release<=1, holding_long<=0, go to IDLE, counter<=0. No pulse_short.
  - Without REPEAT_EN, counter is held at 0.
- Pulse separation: at most one of pulse_press / pulse_short / pulse_long is high in any cycle.
  - pulse_release coincides with pulse_short on short releases.
- Saturation: the counter never wraps. It is cleared on every state change, and the PRESSED threshold is reached before overflow (guaranteed by CNT_W).
- Fast toggling: a re-press one cycle after a release is a new rise from IDLE. Every press produces exactly one pulse_press and exactly one pulse_release.
- Reset mid-hold: all pulses are dropped and the FSM returns to IDLE.
  - If the button is still held when reset deasserts, btn_prev=0 and btn_q=1 produce a rise.
  - A held button at reset release is therefore reported as a new press.

Optional Feature:
- Macro: BOTON_REPEAT_EN.
- Defined: in LONG_HELD, counter increments each cycle.
  - At counter==REPEAT_CYCLES-1: pulse_repeat<=1 and counter<=0.
  - The first repeat comes REPEAT_CYCLES cycles after pulse_long.
  - Fall has priority: no repeat pulse in the release cycle.
- Not defined: pulse_repeat is tied to 0, the repeat logic is absent, and REPEAT_CYCLES is unused.

Test Plan (LONG_CYCLES=10, REPEAT_CYCLES=4 for simulation):
- Reset: hold rst_n=0 with botondebounced=1 → all outputs 0. Release reset → pulse_press one cycle, 2 edges later.
- Short press: input high for 5 cycles then low → pulse_press once, then pulse_short and pulse_release together 5 cycles later; pulse_long never asserts.
- Long press: input high for 20 cycles → pulse_long exactly 10 cycles after pulse_press, holding_long=1. On release: pulse_release only, holding_long→0, no pulse_short.
- Boundary: release so that fall coincides with counter==9 → pulse_short asserted, pulse_long absent, state returns to IDLE.
- Back-to-back presses: pattern 1,1,0,1,1,0 → two pulse_press and two pulse_release, no missed or merged events.
- With BOTON_REPEAT_EN: hold for 30 cycles → pulse_repeat at 4, 8, 12, … cycles after pulse_long, none in the release cycle. Without the macro, pulse_repeat stays 0 throughout.

Source files
------------

// File: rtl/boton_eventos.sv
// -----------------------------------------------------------------------------
// boton_eventos
//   Turns one debounced, active-high button level into single-cycle event
//   pulses (press, short press, long press, release) plus a level showing that
//   a long hold is active. One instance per button, fully in the clk domain.
//
// Optional feature macro: BOTON_REPEAT_EN
//   Defined     -> while long-held, pulse_repeat fires every REPEAT_CYCLES.
//   Not defined -> pulse_repeat is tied to 0 and no repeat logic exists.
//
// Parameters
//   LONG_CYCLES   hold time (clk cycles) that classifies a press as long (>= 2)
//   REPEAT_CYCLES auto-repeat period (clk cycles), BOTON_REPEAT_EN only
//   CNT_W         hold counter width, 2**CNT_W > max(LONG_CYCLES, REPEAT_CYCLES)
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   botondebounced in   debounced button level, 1 = pressed
//   pulse_press    out  one-cycle pulse on press
//   pulse_short    out  one-cycle pulse on release of a short press
//   pulse_long     out  one-cycle pulse when the hold reaches LONG_CYCLES
//   pulse_release  out  one-cycle pulse on any release
//   holding_long   out  level, 1 while in the long-held state
//   pulse_repeat   out  one-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module boton_eventos #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 25_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botondebounced,
    output logic pulse_press,
    output logic pulse_short,
    output logic pulse_long,
    output logic pulse_release,
    output logic holding_long,
    output logic pulse_repeat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONG_HELD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    // Largest threshold the counter ever has to reach; it saturates there so
    // it can never wrap even if a threshold compare were missed.
    localparam int unsigned      CNT_SPAN  = (REPEAT_CYCLES > LONG_CYCLES) ?
                                             REPEAT_CYCLES : LONG_CYCLES;
    localparam logic [CNT_W-1:0] SAT_LAST  = CNT_W'(CNT_SPAN - 1);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic             r_btn_q, r_btn_prev;
    logic             w_rise, w_fall;

    logic r_press, r_short, r_long, r_release, r_hold;
    logic w_press_nx, w_short_nx, w_long_nx, w_release_nx, w_hold_nx;

`ifdef BOTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic r_repeat, w_repeat_nx;
`endif

    assign w_rise    = r_btn_q & ~r_btn_prev;
    assign w_fall    = ~r_btn_q & r_btn_prev;
    assign w_cnt_inc = (r_cnt == SAT_LAST) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_btn_q    <= 1'b0;
            r_btn_prev <= 1'b0;
            r_press    <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_btn_q    <= botondebounced;
            r_btn_prev <= r_btn_q;
            r_press    <= w_press_nx;
            r_short    <= w_short_nx;
            r_long     <= w_long_nx;
            r_release  <= w_release_nx;
            r_hold     <= w_hold_nx;
        end
    end

`ifdef BOTON_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat_nx;
        end
    end
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_press_nx   = 1'b0;
        w_short_nx   = 1'b0;
        w_long_nx    = 1'b0;
        w_release_nx = 1'b0;
        w_hold_nx    = r_hold;
`ifdef BOTON_REPEAT_EN
        w_repeat_nx  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx  = '0;
                w_hold_nx = 1'b0;
                if (w_rise) begin
                    w_state_nx = ST_PRESSED;
                    w_press_nx = 1'b1;
                end
            end
            ST_PRESSED: begin
                // A release on the threshold cycle still counts as short.
                if (w_fall) begin
                    w_state_nx   = ST_IDLE;
                    w_cnt_nx     = '0;
                    w_short_nx   = 1'b1;
                    w_release_nx = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nx = ST_LONG_HELD;
                    w_cnt_nx   = '0;
                    w_long_nx  = 1'b1;
                    w_hold_nx  = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) begin
                    w_state_nx   = ST_IDLE;
                    w_cnt_nx     = '0;
                    w_release_nx = 1'b1;
                    w_hold_nx    = 1'b0;
                end else begin
`ifdef BOTON_REPEAT_EN
                    if (r_cnt == REPEAT_LAST) begin
                        w_cnt_nx    = '0;
                        w_repeat_nx = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
`else
                    w_cnt_nx = '0;
`endif
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_hold_nx  = 1'b0;
            end
        endcase
    end

    assign pulse_press   = r_press;
    assign pulse_short   = r_short;
    assign pulse_long    = r_long;
    assign pulse_release = r_release;
    assign holding_long  = r_hold;
`ifdef BOTON_REPEAT_EN
    assign pulse_repeat  = r_repeat;
`else
    assign pulse_repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_boton_eventos.sv
// -----------------------------------------------------------------------------
// tb_boton_eventos
//   Drives boton_eventos with directed and random button sequences. Each
//   sequence starts from reset; expected pulses are derived per press from the
//   run length of the input (press/short/long/release/repeat timing), not from
//   any state machine.
// -----------------------------------------------------------------------------
module tb_boton_eventos;

    localparam int unsigned L    = 10;
    localparam int unsigned R    = 4;
    localparam int unsigned W    = 5;
    localparam int          MAXN = 128;
`ifdef BOTON_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic pulse_press, pulse_short, pulse_long, pulse_release;
    logic holding_long, pulse_repeat;

    always #5 clk = ~clk;

    boton_eventos #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .botondebounced(btn),
        .pulse_press   (pulse_press),
        .pulse_short   (pulse_short),
        .pulse_long    (pulse_long),
        .pulse_release (pulse_release),
        .holding_long  (holding_long),
        .pulse_repeat  (pulse_repeat)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    // inp[k] is the button level present before post-reset edge k;
    // e_*[k] is the output expected just after edge k.
    logic inp    [MAXN];
    logic e_press[MAXN];
    logic e_short[MAXN];
    logic e_long [MAXN];
    logic e_rel  [MAXN];
    logic e_hold [MAXN];
    logic e_rep  [MAXN];

    task automatic seq_clear();
        n = 0;
    endtask

    task automatic add(input logic v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n < MAXN) begin
                inp[n] = v;
                n++;
            end
        end
    endtask

    // Every run of 1s starting at edge s with length h yields: press at s+1;
    // release at s+h+1; short there if h <= L, otherwise long at s+L+1,
    // holding_long from s+L+1 until the release edge, repeats every R edges
    // after the long pulse but strictly before the release edge.
    function automatic void build_model();
        for (int k = 0; k < MAXN; k++) begin
            e_press[k] = 1'b0; e_short[k] = 1'b0; e_long[k] = 1'b0;
            e_rel[k]   = 1'b0; e_hold[k]  = 1'b0; e_rep[k]  = 1'b0;
        end
        for (int s = 0; s < n; s++) begin
            if (inp[s] && (s == 0 || !inp[s-1])) begin
                int h, rel, lg, last_held;
                bit released;
                h = 0;
                while (s + h < n && inp[s+h]) h++;
                released = (s + h < n);
                rel = s + h + 1;
                if (s + 1 < n) e_press[s+1] = 1'b1;
                if (h <= int'(L)) begin
                    if (released && rel < n) begin
                        e_short[rel] = 1'b1;
                        e_rel[rel]   = 1'b1;
                    end
                end else begin
                    lg = s + int'(L) + 1;
                    last_held = released ? rel - 1 : n - 1;
                    if (lg < n) e_long[lg] = 1'b1;
                    for (int t = lg; t <= last_held && t < n; t++) e_hold[t] = 1'b1;
                    if (released && rel < n) e_rel[rel] = 1'b1;
                    if (REP_ON) begin
                        for (int t = lg + int'(R); t <= last_held && t < n; t += int'(R))
                            e_rep[t] = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string tag, input int edge_no, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d got %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    task automatic run_phase();
        build_model();
        // Reset asserted between edges: only an asynchronous clear zeroes outputs here.
        @(negedge clk);
        rst_n = 1'b0;
        btn   = inp[0];
        #1;
        check("rst_press",   -1, pulse_press,   1'b0);
        check("rst_short",   -1, pulse_short,   1'b0);
        check("rst_long",    -1, pulse_long,    1'b0);
        check("rst_release", -1, pulse_release, 1'b0);
        check("rst_hold",    -1, holding_long,  1'b0);
        check("rst_repeat",  -1, pulse_repeat,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            check("press",   e, pulse_press,   e_press[e]);
            check("short",   e, pulse_short,   e_short[e]);
            check("long",    e, pulse_long,    e_long[e]);
            check("release", e, pulse_release, e_rel[e]);
            check("hold",    e, holding_long,  e_hold[e]);
            check("repeat",  e, pulse_repeat,  e_rep[e]);
            if (e + 1 < n) btn = inp[e+1];
        end
    endtask

    initial begin
        // Button held through reset, then a 5-cycle short press.
        seq_clear(); add(1'b1, 5); add(1'b0, 6); run_phase();
        // Long press held for 20 cycles.
        seq_clear(); add(1'b1, 20); add(1'b0, 5); run_phase();
        // Threshold boundary: 10 cycles is short, 11 is long; plus a 1-cycle tap.
        seq_clear(); add(1'b0, 2); add(1'b1, 10); add(1'b0, 3);
        add(1'b1, 11); add(1'b0, 3); add(1'b1, 1); add(1'b0, 3); run_phase();
        // Back-to-back presses 1,1,0,1,1,0.
        seq_clear(); add(1'b0, 1); add(1'b1, 2); add(1'b0, 1); add(1'b1, 2); add(1'b0, 4); run_phase();
        // Long hold of 30 cycles (auto-repeat when enabled).
        seq_clear(); add(1'b1, 30); add(1'b0, 4); run_phase();
        // Random press/release traffic.
        for (int p = 0; p < 6; p++) begin
            seq_clear();
            while (n < 90) begin
                add(1'b0, int'($urandom_range(1, 5)));
                add(1'b1, int'($urandom_range(1, 25)));
            end
            run_phase();
        end
        // Left in the long-held state, then reset mid-hold with button still down.
        seq_clear(); add(1'b0, 1); add(1'b1, 25); run_phase();
        seq_clear(); add(1'b1, 3); add(1'b0, 3); run_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
